// File: rtl/buf_mem_arbiter.sv
// buf_mem_arbiter: array-priority mux onto one buffer SRAM plus host burst engine.
// Define ARB_STARVE_CNT_EN to add the starve_cnt_o host-starvation counter.
module buf_mem_arbiter #(
  parameter int WIDTH = 8,
  parameter int COL = 4,
  parameter int DEPTH = 256,
  parameter int LEN_W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = COL * WIDTH
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          arr_cenb_i,
  input  logic          arr_wenb_i,
  input  logic [AW-1:0] arr_addr_i,
  input  logic [DW-1:0] arr_data_i,
  output logic [DW-1:0] arr_data_o,
  input  logic          arr_busy_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [DW-1:0] wr_data_i,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic          burst_done_o,
  output logic          mem_cenb_o,
  output logic          mem_wenb_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_q_i
`ifdef ARB_STARVE_CNT_EN
  ,
  output logic [15:0]   starve_cnt_o
`endif
);
  typedef enum logic [2:0] {IDLE, WR, RD, RDRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0] beat_q;
  logic pend_q;
  logic accept, beat_ok, host_wr, host_rd, last;
  // cmd_ready is held low while reset is asserted, even though the FSM already sits in IDLE
  assign cmd_ready_o = (state_q == IDLE) & ~arr_busy_i & rstn_i;
  assign accept = cmd_valid_i & cmd_ready_o;
  assign beat_ok = beat_q <= {1'b0, len_q};
  assign last = beat_q == {1'b0, len_q};
  assign wr_ready_o = (state_q == WR) & wr_valid_i & arr_cenb_i;
  assign host_wr = wr_ready_o;
  assign host_rd = (state_q == RD) & arr_cenb_i & beat_ok;
  assign addr_nx = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
  assign burst_done_o = state_q == DONE;
  assign rd_valid_o = pend_q;
  assign rd_data_o = mem_q_i;
  assign arr_data_o = mem_q_i;
  assign mem_cenb_o = arr_cenb_i ? ~(host_wr | host_rd) : 1'b0;
  assign mem_wenb_o = arr_cenb_i ? ~host_wr : arr_wenb_i;
  assign mem_addr_o = !arr_cenb_i ? arr_addr_i : (host_wr | host_rd) ? addr_q : '0;
  assign mem_data_o = !arr_cenb_i ? arr_data_i : host_wr ? wr_data_i : '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = accept ? (cmd_we_i ? WR : RD) : IDLE;
      WR: state_d = (host_wr & last) ? DONE : WR;
      RD: state_d = (host_rd & last) ? RDRAIN : RD;
      RDRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      beat_q <= '0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= host_rd;
      if (accept) begin
        addr_q <= cmd_addr_i;
        len_q <= cmd_len_i;
        beat_q <= '0;
      end else if (host_wr | host_rd) begin
        addr_q <= addr_nx;
        beat_q <= beat_q + 1'b1;
      end
    end
  end
`ifdef ARB_STARVE_CNT_EN
  logic [15:0] starve_q;
  logic want;
  assign want = ((state_q == WR) & wr_valid_i) | ((state_q == RD) & beat_ok);
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) starve_q <= '0;
    else if (accept) starve_q <= '0;
    else if (want & ~arr_cenb_i & ~&starve_q) starve_q <= starve_q + 1'b1;
  end
  assign starve_cnt_o = starve_q;
`endif
endmodule

// File: tb/tb_buf_mem_arbiter.sv
// tb_buf_mem_arbiter: directed vector and burst-sequence checks against an SRAM model.
module tb_buf_mem_arbiter;
  logic clk = 1'b0;
  logic rstn;
  logic arr_cenb, arr_wenb, arr_busy;
  logic [7:0] arr_addr, cmd_addr, mem_addr;
  logic [31:0] arr_wdata, arr_rdata, wr_data, rd_data, mem_wdata, mem_q;
  logic cmd_valid, cmd_ready, cmd_we, wr_valid, wr_ready, rd_valid, burst_done;
  logic mem_cenb, mem_wenb;
  logic [7:0] cmd_len;
  logic [15:0] starve_cnt;
  logic [31:0] sram [256];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  buf_mem_arbiter dut (
    .clk_i(clk), .rstn_i(rstn),
    .arr_cenb_i(arr_cenb), .arr_wenb_i(arr_wenb), .arr_addr_i(arr_addr),
    .arr_data_i(arr_wdata), .arr_data_o(arr_rdata), .arr_busy_i(arr_busy),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .burst_done_o(burst_done),
    .mem_cenb_o(mem_cenb), .mem_wenb_o(mem_wenb), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_q_i(mem_q)
`ifdef ARB_STARVE_CNT_EN
    , .starve_cnt_o(starve_cnt)
`endif
  );
`ifndef ARB_STARVE_CNT_EN
  assign starve_cnt = '0;
`endif
  always @(posedge clk)
    if (!mem_cenb) begin
      if (!mem_wenb) sram[mem_addr] <= mem_wdata;
      else mem_q <= sram[mem_addr];
    end
  typedef struct {
    logic cenb, wenb;
    logic [7:0] addr;
    logic [31:0] data;
    logic e_cenb, e_wenb;
    logic [7:0] e_addr;
    logic [31:0] e_data;
    logic chk_q;
    logic [31:0] e_q;
  } vec_t;
  vec_t vecs [4];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr_burst(input logic [7:0] a, input logic [7:0] l, input logic [31:0] base);
    int b, n;
    b = 0;
    n = 0;
    cmd_valid = 1; cmd_we = 1; cmd_addr = a; cmd_len = l;
    #1 check("wr_burst_cmd_ready", cmd_ready, 1);
    tick;
    cmd_valid = 0;
    wr_valid = 1;
    while (b <= int'(l) && n < 100) begin
      wr_data = base + b;
      #1;
      if (wr_ready) b++;
      tick;
      n++;
    end
    wr_valid = 0;
    check("wr_burst_beats", b, int'(l) + 1);
    #1 check("wr_burst_done", burst_done, 1);
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    int beat, cyc;
    logic arr_on;
    vecs[0] = '{0, 0, 8'h40, 32'h1122_3344, 0, 0, 8'h40, 32'h1122_3344, 0, 32'h0};
    vecs[1] = '{0, 1, 8'h40, 32'h5566_7788, 0, 1, 8'h40, 32'h5566_7788, 1, 32'h1122_3344};
    vecs[2] = '{1, 0, 8'h77, 32'h0000_0099, 1, 1, 8'h00, 32'h0, 0, 32'h0};
    vecs[3] = '{0, 0, 8'hFF, 32'hDEAD_BEEF, 0, 0, 8'hFF, 32'hDEAD_BEEF, 0, 32'h0};
    for (int i = 0; i < 256; i++) sram[i] = '0;
    mem_q = '0;
    rstn = 0; arr_cenb = 1; arr_wenb = 1; arr_addr = 0; arr_wdata = 0; arr_busy = 0;
    cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_len = 0; wr_valid = 0; wr_data = 0;
    tick;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_burst_done", burst_done, 0);
    check("rst_mem_cenb", mem_cenb, 1);
    check("rst_mem_wenb", mem_wenb, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_wdata, 0);
    tick;
    rstn = 1;
    #1 check("idle_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      arr_cenb = vecs[i].cenb; arr_wenb = vecs[i].wenb;
      arr_addr = vecs[i].addr; arr_wdata = vecs[i].data;
      #1;
      check("vec_mem_cenb", mem_cenb, vecs[i].e_cenb);
      check("vec_mem_wenb", mem_wenb, vecs[i].e_wenb);
      check("vec_mem_addr", mem_addr, vecs[i].e_addr);
      check("vec_mem_data", mem_wdata, vecs[i].e_data);
      tick;
      if (vecs[i].chk_q) begin
        check("vec_arr_data", arr_rdata, vecs[i].e_q);
        check("vec_no_rd_valid", rd_valid, 0);
      end
    end
    arr_cenb = 1; arr_wenb = 1;
    // write burst 10..13 with detailed per-beat checks
    cmd_valid = 1; cmd_we = 1; cmd_addr = 8'h10; cmd_len = 3;
    #1 check("wb_accept", cmd_ready, 1);
    tick;
    wr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'hA000_0000 + i;
      #1;
      check("wb_wr_ready", wr_ready, 1);
      check("wb_mem_addr", mem_addr, 8'h10 + i);
      check("wb_mem_wenb", mem_wenb, 0);
      check("wb_cmd_ignored", cmd_ready, 0);
      tick;
    end
    cmd_valid = 0; wr_valid = 0;
    #1 check("wb_done", burst_done, 1);
    tick;
    check("wb_done_pulse", burst_done, 0);
    for (int i = 0; i < 4; i++) check("wb_sram", sram[8'h10 + i], 32'hA000_0000 + i);
    // read burst 10..13
    cmd_valid = 1; cmd_we = 0; cmd_addr = 8'h10; cmd_len = 3;
    #1 check("rb_accept", cmd_ready, 1);
    tick;
    cmd_valid = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i < 4) begin
        check("rb_issue", mem_cenb, 0);
        check("rb_addr", mem_addr, 8'h10 + i);
      end
      if (i > 0) begin
        check("rb_valid", rd_valid, 1);
        check("rb_data", rd_data, 32'hA000_0000 + i - 1);
      end else check("rb_valid_first", rd_valid, 0);
      tick;
    end
    #1 check("rb_valid_end", rd_valid, 0);
    check("rb_done", burst_done, 1);
    tick;
    // array collision during a write burst
    cmd_valid = 1; cmd_we = 1; cmd_addr = 8'h20; cmd_len = 3;
    #1 check("col_accept", cmd_ready, 1);
    tick;
    cmd_valid = 0; wr_valid = 1;
    beat = 0; cyc = 0;
    while (beat < 4 && cyc < 20) begin
      arr_on = (cyc == 1 || cyc == 2);
      arr_cenb = !arr_on; arr_wenb = 0; arr_addr = 8'h80; arr_wdata = 32'hC000_0000 + cyc;
      wr_data = 32'hB000_0000 + beat;
      #1;
      if (arr_on) begin
        check("col_wr_ready", wr_ready, 0);
        check("col_arr_addr", mem_addr, 8'h80);
      end else check("col_host_addr", mem_addr, 8'h20 + beat);
      if (wr_ready) beat++;
      tick;
      cyc++;
    end
    arr_cenb = 1; arr_wenb = 1; wr_valid = 0;
    check("col_beats", beat, 4);
    check("col_cycles", cyc, 6);
    #1 check("col_done", burst_done, 1);
`ifdef ARB_STARVE_CNT_EN
    check("col_starve", starve_cnt, 2);
`endif
    tick;
    for (int i = 0; i < 4; i++) check("col_sram", sram[8'h20 + i], 32'hB000_0000 + i);
    check("col_arr_sram", sram[8'h80], 32'hC000_0002);
    // address wrap
    wr_burst(8'hFE, 8'd3, 32'hE000_0000);
    check("wrap_fe", sram[8'hFE], 32'hE000_0000);
    check("wrap_ff", sram[8'hFF], 32'hE000_0001);
    check("wrap_00", sram[8'h00], 32'hE000_0002);
    check("wrap_01", sram[8'h01], 32'hE000_0003);
    // busy gating then reset right after a read issue
    arr_busy = 1; cmd_valid = 1; cmd_we = 0; cmd_addr = 8'h10; cmd_len = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("busy_blocked", cmd_ready, 0);
      tick;
    end
    arr_busy = 0;
    #1 check("busy_released", cmd_ready, 1);
    tick;
    cmd_valid = 0;
    #1 check("rst_rd_issue", mem_cenb, 0);
    tick;
    rstn = 0;
    #1;
    check("rstm_rd_valid", rd_valid, 0);
    check("rstm_cmd_ready", cmd_ready, 0);
    check("rstm_mem_cenb", mem_cenb, 1);
    check("rstm_mem_addr", mem_addr, 0);
    check("rstm_burst_done", burst_done, 0);
    tick;
    rstn = 1;
    #1 check("rstm_after_valid", rd_valid, 0);
    check("rstm_after_done", burst_done, 0);
    tick;
    check("rstm_after_valid2", rd_valid, 0);
    cmd_valid = 1; cmd_we = 0; cmd_addr = 8'h11; cmd_len = 0;
    #1 check("rstm_new_accept", cmd_ready, 1);
    tick;
    cmd_valid = 0;
    #1 check("rstm_new_issue", mem_cenb, 0);
    tick;
    check("rstm_new_valid", rd_valid, 1);
    check("rstm_new_data", rd_data, 32'hA000_0001);
    tick;
    check("rstm_new_done", burst_done, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
